// File: rtl/mem_weights_pkg.sv
// Shared constants and state encoding for the weights bank slice.
// Exports: default parameter values and the bank controller state type.
package mem_weights_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 32;
    localparam int unsigned EXTRA_BITS_DEF   = 2;
    localparam int unsigned NUM_UNKNOWNS_DEF = 3;
    localparam int unsigned DEPTH_DEF        = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCopy = 2'd1,
        StRead = 2'd2
    } state_e;

endpackage

// File: rtl/mem_weights_bank_if.sv
// Handshake/bus bundle for mem_weights_bank.
// slave  : the bank itself (write port in, burst port out, control pulses in).
// master : whoever drives weights and reads bursts.
interface mem_weights_bank_if
    import mem_weights_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned EXTRA_BITS = EXTRA_BITS_DEF
) ();
    localparam int unsigned W = DATA_WIDTH + EXTRA_BITS;

    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         init_mode;
    logic         wr_restart;
    logic         commit_best;
    logic         rd_start;
    logic         rd_sel_best;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;
    logic         init_done;

    modport slave (
        input  in_valid, in_data, init_mode, wr_restart, commit_best, rd_start, rd_sel_best,
        output in_ready, out_valid, out_data, out_last, busy, init_done
    );

    modport master (
        output in_valid, in_data, init_mode, wr_restart, commit_best, rd_start, rd_sel_best,
        input  in_ready, out_valid, out_data, out_last, busy, init_done
    );
endinterface

// File: rtl/mem_weights_ram.sv
// W x DEPTH storage with one synchronous write port and one registered read port.
// Reading and writing the same address in one cycle returns the old word.
// Ports: clk, rst (async, clears the read register only), i_we/i_waddr/i_wdata,
//        i_re/i_raddr, o_rdata (holds while i_re is low).
module mem_weights_ram #(
    parameter int unsigned W      = 34,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [W-1:0]      i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [W-1:0]      o_rdata
);
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_weights_bank.sv
// Current/best weight store. Weights stream into the current bank; commit_best
// copies current to best; rd_start emits a DEPTH-word burst from either bank.
// Ports: clk, rst (async, active-high), io_bus (mem_weights_bank_if.slave).
module mem_weights_bank
    import mem_weights_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned EXTRA_BITS   = EXTRA_BITS_DEF,
    parameter int unsigned NUM_UNKNOWNS = NUM_UNKNOWNS_DEF,
    parameter int unsigned DEPTH        = DEPTH_DEF
) (
    input logic              clk,
    input logic              rst,
    mem_weights_bank_if.slave io_bus
);
    localparam int unsigned W      = DATA_WIDTH + EXTRA_BITS;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_LIVE = ADDR_W'(NUM_UNKNOWNS - 1);

    state_e            r_state, w_state_next;
    logic [ADDR_W-1:0] r_rd_ptr, w_rd_ptr_next;
    logic              r_rd_sel, w_rd_sel_next;
    logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_next;
    logic              r_init_done;
    logic              r_copy_we;
    logic [ADDR_W-1:0] r_copy_addr;
    logic              r_out_valid, r_out_last, r_out_sel;
    logic [W-1:0]      r_out_hold;
    logic              w_in_ready, w_accept, w_wr_en, w_wr_wrap;
    logic [W-1:0]      w_cur_rdata, w_best_rdata, w_rd_word;

    // Controller: one address per cycle in COPY and READ, DEPTH addresses each.
    always_comb begin
        w_state_next  = r_state;
        w_rd_ptr_next = r_rd_ptr;
        w_rd_sel_next = r_rd_sel;
        unique case (r_state)
            StIdle: begin
                if (io_bus.commit_best) begin
                    w_state_next  = StCopy;
                    w_rd_ptr_next = '0;
                end else if (io_bus.rd_start) begin
                    w_state_next  = StRead;
                    w_rd_ptr_next = '0;
                    w_rd_sel_next = io_bus.rd_sel_best;
                end
            end
            StCopy, StRead: begin
                if (r_rd_ptr == LAST_ADDR) begin
                    w_state_next  = StIdle;
                    w_rd_ptr_next = '0;
                end else begin
                    w_rd_ptr_next = r_rd_ptr + 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Write side. Live-only updates never touch padding entries.
    assign w_in_ready = (r_state != StCopy);
    assign w_accept   = io_bus.in_valid && w_in_ready && !io_bus.wr_restart;
    assign w_wr_en    = w_accept && (io_bus.init_mode || (r_wr_ptr <= LAST_LIVE));
    assign w_wr_wrap  = io_bus.init_mode ? (r_wr_ptr == LAST_ADDR) : (r_wr_ptr >= LAST_LIVE);

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        if (io_bus.wr_restart) w_wr_ptr_next = '0;
        else if (w_accept)     w_wr_ptr_next = w_wr_wrap ? '0 : r_wr_ptr + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_rd_ptr    <= '0;
            r_rd_sel    <= 1'b0;
            r_wr_ptr    <= '0;
            r_init_done <= 1'b0;
            r_copy_we   <= 1'b0;
            r_copy_addr <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sel   <= 1'b0;
            r_out_hold  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_rd_sel    <= w_rd_sel_next;
            r_wr_ptr    <= w_wr_ptr_next;
            if (w_wr_en && io_bus.init_mode && (r_wr_ptr == LAST_ADDR)) r_init_done <= 1'b1;
            // Copy writes trail the current-bank read by one cycle.
            r_copy_we   <= (r_state == StCopy);
            r_copy_addr <= r_rd_ptr;
            r_out_valid <= (r_state == StRead);
            r_out_last  <= (r_state == StRead) && (r_rd_ptr == LAST_ADDR);
            // Separate select stage so a chained burst cannot flip the final word.
            if (r_state == StRead) r_out_sel <= r_rd_sel;
            if (r_out_valid)       r_out_hold <= w_rd_word;
        end
    end

    mem_weights_ram #(.W(W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_cur (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (io_bus.in_data),
        .i_re    ((r_state == StCopy) || ((r_state == StRead) && !r_rd_sel)),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_cur_rdata)
    );

    mem_weights_ram #(.W(W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_best (
        .clk     (clk),
        .rst     (rst),
        .i_we    (r_copy_we),
        .i_waddr (r_copy_addr),
        .i_wdata (w_cur_rdata),
        .i_re    ((r_state == StRead) && r_rd_sel),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_best_rdata)
    );

    // The current-bank read register moves during COPY, so out_data is held separately.
    assign w_rd_word = r_out_sel ? w_best_rdata : w_cur_rdata;

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_valid ? w_rd_word : r_out_hold;
    assign io_bus.out_last  = r_out_last;
    assign io_bus.busy      = (r_state != StIdle);
    assign io_bus.init_done = r_init_done;
endmodule

// File: tb/tb_mem_weights_bank.sv
module tb_mem_weights_bank;
    localparam int unsigned DW = 32, EB = 2, W = DW + EB, NU = 3, DEPTH = 8;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int unsigned  cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          n_tests = 0, n_fail = 0, n_valid_seen = 0;
    exp_t        q[$];

    logic [W-1:0] m_cur  [DEPTH];
    logic [W-1:0] m_best [DEPTH];
    int           m_ptr = 0;
    bit           m_init_done = 0;
    bit           m_mode = 1;
    logic [W-1:0] m_last_word = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_weights_bank_if #(.DATA_WIDTH(DW), .EXTRA_BITS(EB)) bus ();

    mem_weights_bank #(
        .DATA_WIDTH(DW), .EXTRA_BITS(EB), .NUM_UNKNOWNS(NU), .DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented word must match the oldest expectation, in its cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) begin
                exp_t e;
                n_valid_seen++;
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL burst_word: got %0h with nothing expected (cyc %0d)",
                             bus.out_data, cyc);
                end else begin
                    e = q.pop_front();
                    if (bus.out_data !== e.data || bus.out_last !== e.last || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL burst_word: got %0h last %0b cyc %0d expected %0h last %0b cyc %0d",
                                 bus.out_data, bus.out_last, cyc, e.data, e.last, e.cyc);
                    end
                end
            end else begin
                check("last_without_valid", bus.out_last, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_accept(input logic [W-1:0] d);
        bit wrap;
        if (m_mode || m_ptr < NU) m_cur[m_ptr] = d;
        if (m_mode && m_ptr == DEPTH - 1) m_init_done = 1;
        wrap  = m_mode ? (m_ptr == DEPTH - 1) : (m_ptr >= NU - 1);
        m_ptr = wrap ? 0 : m_ptr + 1;
    endfunction

    task automatic write_word(input logic [W-1:0] d, input bit restart);
        bit rdy;
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.wr_restart = restart;
        rdy            = bus.in_ready;
        step();
        bus.in_valid   = 1'b0;
        bus.wr_restart = 1'b0;
        if (restart)  m_ptr = 0;
        else if (rdy) model_accept(d);
        repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic set_mode(input bit mode);
        bus.init_mode  = mode;
        m_mode         = mode;
        bus.wr_restart = 1'b1;
        step();
        bus.wr_restart = 1'b0;
        m_ptr          = 0;
    endtask

    // Issues rd_start; returns the cycle count just after the sampling edge.
    task automatic start_read(input bit sel, output int unsigned c);
        bus.rd_start    = 1'b1;
        bus.rd_sel_best = sel;
        @(posedge clk);
        #1;
        bus.rd_start    = 1'b0;
        c = cyc;
    endtask

    task automatic expect_bank(input bit sel, input int unsigned c);
        for (int i = 0; i < DEPTH; i++) begin
            exp_t e;
            e.data = sel ? m_best[i] : m_cur[i];
            e.last = (i == DEPTH - 1);
            e.cyc  = c + 1 + i;
            q.push_back(e);
            m_last_word = e.data;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q.size() != 0 || bus.busy || bus.out_valid) && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) check({name, "_timeout"}, 1, 0);
        step();
    endtask

    task automatic read_bank(input bit sel, input string name);
        int unsigned c;
        start_read(sel, c);
        expect_bank(sel, c);
        wait_drain(name);
        check({name, "_hold"}, bus.out_data, m_last_word);
    endtask

    task automatic commit();
        bus.commit_best = 1'b1;
        step();
        bus.commit_best = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_best[i] = m_cur[i];
        wait_drain("commit");
    endtask

    logic [W-1:0] lit [DEPTH];

    initial begin
        int unsigned c, c2;
        int n0, nv0;
        logic [W-1:0] d;

        bus.in_valid = 0; bus.in_data = '0; bus.init_mode = 1; bus.wr_restart = 0;
        bus.commit_best = 0; bus.rd_start = 0; bus.rd_sel_best = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_init_done", bus.init_done, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_data", bus.out_data, 0);
        rst = 1'b0;
        step();

        // Full init pass 0x10..0x17.
        set_mode(1);
        for (int i = 0; i < DEPTH; i++) begin
            check("init_done_early", bus.init_done, 0);
            write_word(W'(32'h10 + i), 0);
        end
        check("init_done_set", bus.init_done, 1);
        start_read(0, c);
        for (int i = 0; i < DEPTH; i++) begin
            exp_t e;
            e.data = W'(32'h10 + i); e.last = (i == DEPTH - 1); e.cyc = c + 1 + i;
            q.push_back(e);
        end
        wait_drain("init_burst");
        check("init_hold", bus.out_data, W'(32'h17));

        // Live-only update wraps at NU-1; padding untouched.
        set_mode(0);
        for (int i = 0; i < 6; i++) write_word(W'(32'hA0 + i), 0);
        lit[0] = W'(32'hA3); lit[1] = W'(32'hA4); lit[2] = W'(32'hA5);
        for (int i = 3; i < DEPTH; i++) lit[i] = W'(32'h10 + i);
        start_read(0, c);
        for (int i = 0; i < DEPTH; i++) begin
            exp_t e;
            e.data = lit[i]; e.last = (i == DEPTH - 1); e.cyc = c + 1 + i;
            q.push_back(e);
        end
        wait_drain("live_burst");

        // wr_restart beats a simultaneous accept.
        write_word(W'(32'h1234), 0);
        write_word(W'(32'hDEAD), 1);
        write_word(W'(32'h5555), 0);
        read_bank(0, "restart_burst");

        // Commit with in_valid held: in_ready low for exactly DEPTH cycles.
        bus.commit_best = 1'b1;
        step();
        bus.commit_best = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_best[i] = m_cur[i];
        check("copy_busy", bus.busy, 1);
        d = W'(32'h77);
        bus.in_valid = 1'b1; bus.in_data = d; n0 = 0;
        for (int i = 0; i < 20 && !bus.in_ready; i++) begin
            n0++;
            step();
        end
        check("copy_stall_cycles", n0, DEPTH);
        step();
        bus.in_valid = 1'b0;
        model_accept(d);
        read_bank(1, "best_burst");
        read_bank(0, "cur_after_commit");

        // commit_best and rd_start together: copy only.
        nv0 = n_valid_seen;
        bus.commit_best = 1'b1; bus.rd_start = 1'b1; bus.rd_sel_best = 0;
        step();
        bus.commit_best = 1'b0; bus.rd_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_best[i] = m_cur[i];
        check("dual_in_ready", bus.in_ready, 0);
        repeat (DEPTH + 4) step();
        check("dual_no_output", n_valid_seen - nv0, 0);
        read_bank(1, "dual_best_burst");

        // Randomized mix against the model.
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    bit mode = 1'($urandom_range(0, 1));
                    if (mode != m_mode) set_mode(mode);
                    repeat ($urandom_range(1, 10))
                        write_word({2'($urandom_range(0, 3)), 32'($urandom)}, 0);
                    check("rand_init_done", bus.init_done, m_init_done);
                end
                1: read_bank(0, "rand_cur");
                2: read_bank(1, "rand_best");
                default: commit();
            endcase
        end

        // rd_start on the out_last cycle chains a second burst.
        nv0 = n_valid_seen;
        start_read(0, c);
        expect_bank(0, c);
        while (cyc < c + DEPTH) step();
        check("chain_last_seen", bus.out_last, 1);
        start_read(1, c2);
        expect_bank(1, c2);
        wait_drain("chain");
        check("chain_word_count", n_valid_seen - nv0, 2 * DEPTH);

        // Reset on the 4th word aborts the burst.
        start_read(0, c);
        expect_bank(0, c);
        while (cyc < c + 4) step();
        check("pre_rst_valid", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        check("rst_abort_valid", bus.out_valid, 0);
        check("rst_abort_busy", bus.busy, 0);
        check("rst_abort_data", bus.out_data, 0);
        step();
        rst = 1'b0;
        m_ptr = 0; m_init_done = 0;
        check("rst_abort_init_done", bus.init_done, 0);
        step();

        // Banks are undefined after reset; rewrite then read cleanly.
        set_mode(1);
        for (int i = 0; i < DEPTH; i++) write_word({2'($urandom_range(0, 3)), 32'($urandom)}, 0);
        check("post_rst_init_done", bus.init_done, 1);
        read_bank(0, "post_rst_burst");
        commit();
        read_bank(1, "post_rst_best");

        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
